// File: rtl/fetch_prefetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_stage_if
//   Bundles the control, program-load and IF/ID signals of the fetch stage.
//   master : the surrounding pipeline / debug unit (drives i_*, reads o_*)
//   slave  : the fetch stage itself (reads i_*, drives o_*)
//   Signals:
//     i_valid / i_stall / i_pc_src / i_pc_next : fetch enable, ID stall, redirect
//     i_wr_enable / i_wr_addr / i_wr_data      : instruction memory program load
//     o_instruction / o_pc_next / o_rs / o_rt  : FIFO head presented to ID
//     o_valid / o_halt / o_fetch_pc            : head status, halt flag, debug PC
// -----------------------------------------------------------------------------
interface fetch_prefetch_stage_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 10,
    parameter int NB_REGISTER = 5
);
    logic                   i_valid;
    logic                   i_stall;
    logic                   i_pc_src;
    logic [NB_DATA-1:0]     i_pc_next;
    logic                   i_wr_enable;
    logic [NB_ADDR-1:0]     i_wr_addr;
    logic [NB_DATA-1:0]     i_wr_data;
    logic [NB_DATA-1:0]     o_instruction;
    logic [NB_DATA-1:0]     o_pc_next;
    logic [NB_REGISTER-1:0] o_rs;
    logic [NB_REGISTER-1:0] o_rt;
    logic                   o_valid;
    logic                   o_halt;
    logic [NB_DATA-1:0]     o_fetch_pc;

    modport master (
        output i_valid, i_stall, i_pc_src, i_pc_next,
        output i_wr_enable, i_wr_addr, i_wr_data,
        input  o_instruction, o_pc_next, o_rs, o_rt, o_valid, o_halt, o_fetch_pc
    );

    modport slave (
        input  i_valid, i_stall, i_pc_src, i_pc_next,
        input  i_wr_enable, i_wr_addr, i_wr_data,
        output o_instruction, o_pc_next, o_rs, o_rt, o_valid, o_halt, o_fetch_pc
    );
endinterface

// File: rtl/fetch_prefetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_stage
//   MIPS instruction-fetch stage. Holds the PC, a synchronous-read instruction
//   memory with a program-load write port, and a small prefetch FIFO so that
//   fetch keeps running while decode is stalled. Handles redirect/flush and
//   HALT detection via a RUN/HALTED state machine.
//   Ports:
//     i_clock : rising-edge clock
//     i_reset : synchronous active-high reset
//     bus     : fetch_prefetch_stage_if.slave (control in, IF/ID out)
// -----------------------------------------------------------------------------
module fetch_prefetch_stage #(
    parameter int         NB_DATA     = 32,
    parameter int         NB_ADDR     = 10,
    parameter int         NB_REGISTER = 5,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    fetch_prefetch_stage_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    // Storage (no reset: contents are qualified by count/inflight)
    logic [NB_DATA-1:0] imem [2**NB_ADDR];
    logic [NB_DATA-1:0] fifo_instr_mem [FIFO_DEPTH];
    logic [NB_DATA-1:0] fifo_pc_mem    [FIFO_DEPTH];
    logic [NB_DATA-1:0] rd_data_q;

    state_t             state_q,    state_d;
    logic [NB_DATA-1:0] pc_q,       pc_d;
    logic [NB_DATA-1:0] rd_pc_q,    rd_pc_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;

    logic               run, head_valid, head_is_halt;
    logic               flush, pop, halt_pop, issue, push;
    logic [CNT_W:0]     occupancy;
    logic [NB_DATA-1:0] head_instr, head_pc, out_instr;

    always_comb begin
        run          = (state_q == ST_RUN);
        head_instr   = fifo_instr_mem[rd_ptr_q];
        head_pc      = fifo_pc_mem[rd_ptr_q];
        head_valid   = (count_q != '0);
        head_is_halt = head_valid && (head_instr[NB_DATA-1 -: 6] == HALT_OPCODE);
        // Entries already queued plus the read in flight must leave a free slot,
        // so a stall never drops the word arriving from memory.
        occupancy    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

        flush    = run && bus.i_pc_src;
        pop      = head_valid && !bus.i_stall && !bus.i_pc_src;
        halt_pop = pop && head_is_halt;
        // Halt retirement freezes the PC on that very edge, hence !halt_pop.
        issue    = run && bus.i_valid && !bus.i_pc_src && !halt_pop && (occupancy < OCC_MAX);
        push     = inflight_q && !flush && !halt_pop;

        state_d    = state_q;
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (issue) begin
            pc_d    = pc_q + NB_DATA'(1);
            rd_pc_d = pc_q + NB_DATA'(1);
        end

        if (flush) begin
            pc_d     = bus.i_pc_next;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (halt_pop) begin
            state_d  = ST_HALTED;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Instruction memory: write port for program load, registered read port.
    // A same-edge write/read to one index returns the old word.
    always_ff @(posedge i_clock) begin
        if (bus.i_wr_enable) begin
            imem[bus.i_wr_addr] <= bus.i_wr_data;
        end
        if (issue) begin
            rd_data_q <= imem[pc_q[NB_ADDR-1:0]];
        end
    end

    always_ff @(posedge i_clock) begin
        if (push && !i_reset) begin
            fifo_instr_mem[wr_ptr_q] <= rd_data_q;
            fifo_pc_mem[wr_ptr_q]    <= rd_pc_q;
        end
    end

    always_comb begin
        out_instr         = head_valid ? head_instr : '0;
        bus.o_instruction = out_instr;
        bus.o_pc_next     = head_valid ? head_pc : '0;
        bus.o_rs          = out_instr[25 -: NB_REGISTER];
        bus.o_rt          = out_instr[20 -: NB_REGISTER];
        bus.o_valid       = head_valid;
        bus.o_halt        = head_is_halt || !run;
        bus.o_fetch_pc    = pc_q;
    end
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
module tb_fetch_prefetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;

    always #5 clk = ~clk;

    fetch_prefetch_stage_if #(.NB_DATA(32), .NB_ADDR(10), .NB_REGISTER(5)) bus ();

    fetch_prefetch_stage #(
        .NB_DATA(32), .NB_ADDR(10), .NB_REGISTER(5),
        .FIFO_DEPTH(4), .HALT_OPCODE(6'b111111)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("[TB] cyc=%0d valid=%0b pc_next=0x%0h instr=0x%08h halt=%0b fetch_pc=0x%0h",
                 cyc, bus.o_valid, bus.o_pc_next, bus.o_instruction, bus.o_halt, bus.o_fetch_pc);
    endtask

    task automatic flush_to(input logic [31:0] target);
        bus.i_pc_src  = 1'b1;
        bus.i_pc_next = target;
        step();
        bus.i_pc_src  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_pc_src    = 1'b0;
        bus.i_pc_next   = '0;
        bus.i_wr_enable = 1'b0;
        bus.i_wr_addr   = '0;
        bus.i_wr_data   = '0;

        // Program load under reset
        for (int i = 0; i < 32; i++) begin
            bus.i_wr_enable = 1'b1;
            bus.i_wr_addr   = 10'(i);
            bus.i_wr_data   = 32'h100 + 32'(i);
            step();
        end
        bus.i_wr_enable = 1'b0;
        check("rst_valid",    32'(bus.o_valid), 32'd0);
        check("rst_fetch_pc", bus.o_fetch_pc, 32'd0);
        check("rst_halt",     32'(bus.o_halt), 32'd0);
        check("rst_instr",    bus.o_instruction, 32'd0);
        check("rst_pc_next",  bus.o_pc_next, 32'd0);

        // 1. Sequential fetch, 2-edge latency
        rst = 1'b0;
        bus.i_valid = 1'b1;
        step();
        check("lat_valid_e1", 32'(bus.o_valid), 32'd0);
        check("lat_pc_e1",    bus.o_fetch_pc, 32'd1);
        step();
        check("lat_valid_e2", 32'(bus.o_valid), 32'd1);
        check("lat_pcn_e2",   bus.o_pc_next, 32'd1);
        check("lat_ins_e2",   bus.o_instruction, 32'h100);
        for (int n = 3; n <= 8; n++) begin
            step();
            check("seq_pcn", bus.o_pc_next, 32'(n - 1));
            check("seq_ins", bus.o_instruction, 32'h100 + 32'(n - 2));
        end

        // 2. Stall burst: head holds, PC stops once FIFO is full
        bus.i_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall_pcn", bus.o_pc_next, 32'd7);
            check("stall_ins", bus.o_instruction, 32'h106);
        end
        check("stall_fetch_pc", bus.o_fetch_pc, 32'd10);
        bus.i_stall = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("drain_pcn", bus.o_pc_next, 32'(7 + k));
        end
        check("drain_ins",      bus.o_instruction, 32'h110);
        check("drain_fetch_pc", bus.o_fetch_pc, 32'd19);

        // 3. Redirect to 0x14
        flush_to(32'h14);
        check("fl_valid0", 32'(bus.o_valid), 32'd0);
        check("fl_pc",     bus.o_fetch_pc, 32'h14);
        step();
        check("fl_valid1", 32'(bus.o_valid), 32'd0);
        step();
        check("fl_valid2", 32'(bus.o_valid), 32'd1);
        check("fl_pcn",    bus.o_pc_next, 32'h15);
        check("fl_ins",    bus.o_instruction, 32'h114);
        step();
        check("fl_pcn2",   bus.o_pc_next, 32'h16);

        // 6. Write to the index being fetched on the same edge -> old word
        bus.i_wr_enable = 1'b1;
        bus.i_wr_addr   = 10'h17;
        bus.i_wr_data   = 32'hDEADBEEF;
        step();
        bus.i_wr_enable = 1'b0;
        check("wr_pcn_a", bus.o_pc_next, 32'h17);
        step();
        check("wr_pcn_b", bus.o_pc_next, 32'h18);
        check("wr_old",   bus.o_instruction, 32'h117);
        flush_to(32'h17);
        step();
        step();
        check("wr_new_pcn", bus.o_pc_next, 32'h18);
        check("wr_new",     bus.o_instruction, 32'hDEADBEEF);
        check("wr_new_rs",  32'(bus.o_rs), 32'h15);
        check("wr_new_rt",  32'(bus.o_rt), 32'h0D);

        // Plant HALT at imem[5]
        bus.i_wr_enable = 1'b1;
        bus.i_wr_addr   = 10'd5;
        bus.i_wr_data   = 32'hFC000000;
        step();
        bus.i_wr_enable = 1'b0;

        // 5a. HALT at head with a redirect on the same edge -> redirect wins
        flush_to(32'd5);
        step();
        step();
        check("h5_halt", 32'(bus.o_halt), 32'd1);
        check("h5_ins",  bus.o_instruction, 32'hFC000000);
        check("h5_pcn",  bus.o_pc_next, 32'd6);
        flush_to(32'h10);
        check("h5_halt_after", 32'(bus.o_halt), 32'd0);
        check("h5_valid",      32'(bus.o_valid), 32'd0);
        check("h5_pc",         bus.o_fetch_pc, 32'h10);
        step();
        step();
        check("h5_run_pcn", bus.o_pc_next, 32'h11);
        check("h5_run_ins", bus.o_instruction, 32'h110);

        // 4. HALT retired -> HALTED, PC frozen
        flush_to(32'd5);
        step();
        step();
        check("h4_halt_head", 32'(bus.o_halt), 32'd1);
        check("h4_valid_head", 32'(bus.o_valid), 32'd1);
        step();
        check("h4_valid", 32'(bus.o_valid), 32'd0);
        check("h4_halt",  32'(bus.o_halt), 32'd1);
        check("h4_pc",    bus.o_fetch_pc, 32'd7);
        for (int k = 0; k < 20; k++) begin
            bus.i_pc_src  = (k % 5 == 0);
            bus.i_pc_next = 32'd3;
            step();
            check("hd_pc",    bus.o_fetch_pc, 32'd7);
            check("hd_valid", 32'(bus.o_valid), 32'd0);
            check("hd_halt",  32'(bus.o_halt), 32'd1);
        end
        bus.i_pc_src = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hr_pc",    bus.o_fetch_pc, 32'd0);
        check("hr_valid", 32'(bus.o_valid), 32'd0);
        check("hr_halt",  32'(bus.o_halt), 32'd0);
        step();
        step();
        check("hr_run_valid", 32'(bus.o_valid), 32'd1);
        check("hr_run_pcn",   bus.o_pc_next, 32'd1);

        // 5b. Reset while FIFO is full
        bus.i_stall = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("full_pc",  bus.o_fetch_pc, 32'd4);
        check("full_pcn", bus.o_pc_next, 32'd1);
        rst = 1'b1;
        step();
        check("fr_valid", 32'(bus.o_valid), 32'd0);
        check("fr_pc",    bus.o_fetch_pc, 32'd0);
        check("fr_pcn",   bus.o_pc_next, 32'd0);
        rst = 1'b0;
        bus.i_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
